// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out framed transmitter.
// Frame on an idle-high line: start (0), WIDTH data bits LSB first, optional parity, stop (1).
// Each bit is held for CLKS_PER_BIT cycles. All outputs come straight from flops.
module piso_serial_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] TimerLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BitLast   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             bit_end;

  assign bit_end = (timer_q == TimerLast);

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ready is always high in idle, so valid alone marks acceptance
        if (din_valid) begin
          shreg_d  = din;
          // parity taken from the word as accepted, not from the shifting copy
          par_d    = (^din) ^ (PARITY_ODD != 0);
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == BitLast) begin
            bitcnt_d = '0;
            state_d  = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StParity: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StStop;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered line level, busy and ready as functions of the upcoming state.
  always_comb begin
    dout_d  = 1'b1;
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
    unique case (state_d)
      StIdle:   dout_d = 1'b1;
      StStart:  dout_d = 1'b0;
      StData:   dout_d = shreg_d[0];
      StParity: dout_d = par_d;
      StStop:   dout_d = 1'b1;
      default:  dout_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign din_ready = ready_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: four instances with different parameter sets share inputs.
// 0: even parity, 1: odd parity, 2: no parity, 3: even parity with 4 clocks per bit.
module tb_piso_serial_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic [3:0] dout_w, ready_w, busy_w, done_w;

  int checks;
  int errors;

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready_w[0]), .dout(dout_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready_w[1]), .dout(dout_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready_w[2]), .dout(dout_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_slow (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready_w[3]), .dout(dout_w[3]), .busy(busy_w[3]), .done(done_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       pe;  // hand-computed even parity bit of word
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One frame through the three single-clock instances, checked cycle by cycle.
  task automatic run_vec(input int idx);
    logic [10:0] e_even;
    logic [10:0] e_odd;
    logic [9:0]  e_nop;
    e_even = {1'b1, vecs[idx].pe, vecs[idx].word, 1'b0};
    e_odd  = {1'b1, ~vecs[idx].pe, vecs[idx].word, 1'b0};
    e_nop  = {1'b1, vecs[idx].word, 1'b0};
    @(negedge clk);
    din = vecs[idx].word;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = ~vecs[idx].word;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) begin
        chk($sformatf("v%0d even dout c%0d", idx, c), int'(dout_w[0]), int'(e_even[c-1]));
        chk($sformatf("v%0d odd dout c%0d", idx, c), int'(dout_w[1]), int'(e_odd[c-1]));
        chk($sformatf("v%0d busy c%0d", idx, c), int'(busy_w[0]), 1);
        chk($sformatf("v%0d ready c%0d", idx, c), int'(ready_w[0]), 0);
        chk($sformatf("v%0d done c%0d", idx, c), int'(done_w[0]), 0);
      end else begin
        chk($sformatf("v%0d even done", idx), int'(done_w[0]), 1);
        chk($sformatf("v%0d odd done", idx), int'(done_w[1]), 1);
        chk($sformatf("v%0d idle dout", idx), int'(dout_w[0]), 1);
        chk($sformatf("v%0d idle busy", idx), int'(busy_w[0]), 0);
        chk($sformatf("v%0d idle ready", idx), int'(ready_w[0]), 1);
      end
      if (c <= 10) begin
        chk($sformatf("v%0d nopar dout c%0d", idx, c), int'(dout_w[2]), int'(e_nop[c-1]));
        chk($sformatf("v%0d nopar done c%0d", idx, c), int'(done_w[2]), 0);
      end else if (c == 11) begin
        chk($sformatf("v%0d nopar done", idx), int'(done_w[2]), 1);
        chk($sformatf("v%0d nopar idle dout", idx), int'(dout_w[2]), 1);
      end else begin
        chk($sformatf("v%0d nopar done drop", idx), int'(done_w[2]), 0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [10:0] e1;
    logic [10:0] e2;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;

    vecs[0] = '{word: 8'hA5, pe: 1'b0};
    vecs[1] = '{word: 8'h01, pe: 1'b1};
    vecs[2] = '{word: 8'h3C, pe: 1'b0};
    vecs[3] = '{word: 8'h80, pe: 1'b1};
    vecs[4] = '{word: 8'h7E, pe: 1'b0};
    vecs[5] = '{word: 8'h13, pe: 1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst dout", int'(dout_w[0]), 1);
    chk("rst ready", int'(ready_w[0]), 1);
    chk("rst busy", int'(busy_w[0]), 0);
    chk("rst done", int'(done_w[0]), 0);
    chk("rst slow dout", int'(dout_w[3]), 1);
    chk("rst slow ready", int'(ready_w[3]), 1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_vec(i);
    end

    // Back-to-back with din_valid held high, din wiggled during the second frame
    do_reset();
    e1 = {1'b1, 1'b0, 8'hFF, 1'b0};
    e2 = {1'b1, 1'b0, 8'h00, 1'b0};
    @(negedge clk);
    din = 8'hFF;
    din_valid = 1'b1;
    @(negedge clk);
    din = 8'h00;
    for (int c = 1; c <= 24; c++) begin
      if (c <= 11) begin
        chk($sformatf("b2b f1 dout c%0d", c), int'(dout_w[0]), int'(e1[c-1]));
        chk($sformatf("b2b f1 ready c%0d", c), int'(ready_w[0]), 0);
      end else if (c == 12) begin
        chk("b2b gap dout", int'(dout_w[0]), 1);
        chk("b2b gap done", int'(done_w[0]), 1);
        chk("b2b gap ready", int'(ready_w[0]), 1);
      end else if (c <= 23) begin
        chk($sformatf("b2b f2 dout c%0d", c), int'(dout_w[0]), int'(e2[c-13]));
        chk($sformatf("b2b f2 ready c%0d", c), int'(ready_w[0]), 0);
        chk($sformatf("b2b f2 busy c%0d", c), int'(busy_w[0]), 1);
        din_valid = 1'b0;
        din = 8'(c * 37) ^ 8'hC3;
      end else begin
        chk("b2b f2 done", int'(done_w[0]), 1);
        chk("b2b f2 idle dout", int'(dout_w[0]), 1);
      end
      @(negedge clk);
    end

    // Reset during data bit 3, then a clean frame
    do_reset();
    @(negedge clk);
    din = 8'hA5;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid bit3 dout", int'(dout_w[0]), 0);
    chk("mid bit3 busy", int'(busy_w[0]), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst dout", int'(dout_w[0]), 1);
    chk("mid rst busy", int'(busy_w[0]), 0);
    chk("mid rst ready", int'(ready_w[0]), 1);
    chk("mid rst done", int'(done_w[0]), 0);
    rst = 1'b1;
    din = 8'h5A;
    din_valid = 1'b1;
    e1 = {1'b1, 1'b0, 8'h5A, 1'b0};
    @(negedge clk);
    din_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) begin
        chk($sformatf("post rst dout c%0d", c), int'(dout_w[0]), int'(e1[c-1]));
        chk($sformatf("post rst done c%0d", c), int'(done_w[0]), 0);
      end else begin
        chk("post rst done", int'(done_w[0]), 1);
      end
      @(negedge clk);
    end

    // Four clocks per bit
    do_reset();
    e1 = {1'b1, 1'b0, 8'h3C, 1'b0};
    @(negedge clk);
    din = 8'h3C;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      if (c <= 44) begin
        chk($sformatf("slow dout c%0d", c), int'(dout_w[3]), int'(e1[(c-1)/4]));
        chk($sformatf("slow busy c%0d", c), int'(busy_w[3]), 1);
        chk($sformatf("slow done c%0d", c), int'(done_w[3]), 0);
      end else if (c == 45) begin
        chk("slow done", int'(done_w[3]), 1);
        chk("slow idle busy", int'(busy_w[3]), 0);
        chk("slow idle ready", int'(ready_w[3]), 1);
      end else begin
        chk("slow done drop", int'(done_w[3]), 0);
        chk("slow idle dout", int'(dout_w[3]), 1);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
